// File: rtl/alu_issue_ctrl_pkg.sv
// Shared ALU opcode and controller-state types for the EX-stage ALU, its control
// decoder and the issue controller.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND     = 3'b000,
        OP_OR      = 3'b001,
        OP_ADD     = 3'b010,
        OP_MUL     = 3'b011,
        OP_SUB     = 3'b110,
        OP_INVALID = 3'b111
    } alu_op_t;

    typedef enum logic {
        IDLE,
        MUL_RUN
    } ctrl_state_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// ID/EX to ALU issue bus: operation handshake, result strobe and pipeline stall.
interface alu_issue_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    import alu_pkg::*;

    logic             valid_i;
    logic             ready_o;
    logic [2:0]       op_i;
    logic [WIDTH-1:0] data1_i;
    logic [WIDTH-1:0] data2_i;
    logic [WIDTH-1:0] result_o;
    logic             valid_o;
    logic             err_o;
    logic             stall_o;

    modport master (
        output valid_i, op_i, data1_i, data2_i,
        input  ready_o, result_o, valid_o, err_o, stall_o
    );

    modport slave (
        input  valid_i, op_i, data1_i, data2_i,
        output ready_o, result_o, valid_o, err_o, stall_o
    );

endinterface

// File: rtl/alu_issue_ctrl_mul_iter.sv
// Iterative shift-add multiplier: one partial product per step, low WIDTH bits kept.
// ALU_MUL_EARLY_EXIT_EN: also finishes on the step that consumes the last set multiplier bit.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             step_i,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [CW-1:0]    cnt_q;
    logic             last;

    always_comb begin
        acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
        last  = (cnt_q == CW'(WIDTH - 1));
`ifdef ALU_MUL_EARLY_EXIT_EN
        last  = last || ((mplier_q >> 1) == '0);
`endif
        done_o    = step_i && last;
        // Product includes the partial sum of the finishing step.
        product_o = acc_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (start_i) begin
            mcand_q  <= a_i;
            mplier_q <= b_i;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (step_i) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// EX-stage ALU issue controller: single-cycle AND/OR/ADD/SUB, iterative MUL with stall.
// Optional macro ALU_MUL_EARLY_EXIT_EN enables early MUL completion in alu_mul_iter.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic           clk_i,
    input  logic           rst_i,
    alu_issue_ctrl_if.slave bus
);

    ctrl_state_t      state_q;
    logic [WIDTH-1:0] result_q;
    logic             valid_q;
    logic             err_q;
    logic             ready_q;
    logic             stall_q;

    logic             accept;
    logic             mul_start;
    logic             mul_step;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    always_comb begin
        accept    = bus.valid_i && ready_q;
        mul_start = accept && (state_q == IDLE) && (bus.op_i == OP_MUL);
        mul_step  = (state_q == MUL_RUN);
    end

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (mul_start),
        .a_i       (bus.data1_i),
        .b_i       (bus.data2_i),
        .step_i    (mul_step),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            result_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            ready_q  <= 1'b1;
            stall_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        valid_q <= 1'b1;
                        err_q   <= 1'b0;
                        case (bus.op_i)
                            OP_AND: result_q <= bus.data1_i & bus.data2_i;
                            OP_OR:  result_q <= bus.data1_i | bus.data2_i;
                            OP_ADD: result_q <= bus.data1_i + bus.data2_i;
                            OP_SUB: result_q <= bus.data1_i + ~bus.data2_i + WIDTH'(1);
                            OP_MUL: begin
                                valid_q <= 1'b0;
                                ready_q <= 1'b0;
                                stall_q <= 1'b1;
                                state_q <= MUL_RUN;
                            end
                            default: begin
                                result_q <= '0;
                                err_q    <= 1'b1;
                            end
                        endcase
                    end else begin
                        valid_q <= 1'b0;
                    end
                end
                MUL_RUN: begin
                    if (mul_done) begin
                        result_q <= mul_product;
                        valid_q  <= 1'b1;
                        err_q    <= 1'b0;
                        ready_q  <= 1'b1;
                        stall_q  <= 1'b0;
                        state_q  <= IDLE;
                    end else begin
                        valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.result_o = result_q;
    assign bus.valid_o  = valid_q;
    assign bus.err_o    = err_q;
    assign bus.ready_o  = ready_q;
    assign bus.stall_o  = stall_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: expected result/err/arrival time queued at drive time.
module tb_alu_issue_ctrl;

    localparam int unsigned WIDTH = 32;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             err;
        longint           due;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    exp_t   sb[$];
    int     errors = 0;
    int     checks = 0;

    alu_issue_ctrl_if #(.WIDTH(WIDTH)) bus ();

    alu_issue_ctrl #(.WIDTH(WIDTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lat_of(input logic [2:0] op, input logic [WIDTH-1:0] b);
        int hb = 0;
        for (int i = 0; i < int'(WIDTH); i++)
            if (b[i]) hb = i + 1;
        if (op != 3'b011) return 1;
`ifdef ALU_MUL_EARLY_EXIT_EN
        return 1 + ((hb < 1) ? 1 : hb);
`else
        return int'(WIDTH) + 1 + (hb * 0);
`endif
    endfunction

    task automatic issue(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (!bus.ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ready_o) check("ready_timeout", 64'(bus.ready_o), 64'd1);
        bus.valid_i = 1'b1;
        bus.op_i    = op;
        bus.data1_i = a;
        bus.data2_i = b;
        e.err = 1'b0;
        case (op)
            3'b000:  e.res = a & b;
            3'b001:  e.res = a | b;
            3'b010:  e.res = a + b;
            3'b011:  e.res = a * b;
            3'b110:  e.res = a - b;
            default: begin e.res = '0; e.err = 1'b1; end
        endcase
        e.due = longint'($time) + longint'(lat_of(op, b)) * 10;
        sb.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.valid_i = 1'b0;
    endtask

    // Output monitor: every valid_o pulse must match the oldest expectation, on time.
    always @(negedge clk) begin
        if (!rst && bus.valid_o) begin
            if (sb.size() == 0) begin
                check("spurious_valid", 64'(bus.valid_o), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", 64'(bus.result_o), 64'(e.res));
                check("err", 64'(bus.err_o), 64'(e.err));
                check("latency", 64'($time), 64'(e.due));
            end
        end
    end

    initial begin
        bus.valid_i = 1'b0;
        bus.op_i    = '0;
        bus.data1_i = '0;
        bus.data2_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_result", 64'(bus.result_o), 64'd0);
        check("rst_valid", 64'(bus.valid_o), 64'd0);
        check("rst_err", 64'(bus.err_o), 64'd0);
        check("rst_stall", 64'(bus.stall_o), 64'd0);
        check("rst_ready", 64'(bus.ready_o), 64'd1);
        rst = 1'b0;

        // ADD, ready must stay high
        issue(3'b010, 32'd5, 32'd7);
        idle();
        check("add_ready", 64'(bus.ready_o), 64'd1);

        // back-to-back SUB then OR
        issue(3'b110, 32'd3, 32'd5);
        issue(3'b001, 32'h0000_00F0, 32'h0000_000F);
        idle();

        // MUL with stall, and valid_i held while stalled must be ignored
        issue(3'b011, 32'd6, 32'd7);
        idle();
        check("mul_stall", 64'(bus.stall_o), 64'd1);
        check("mul_ready", 64'(bus.ready_o), 64'd0);
        bus.op_i    = 3'b010;
        bus.data1_i = 32'd9;
        bus.data2_i = 32'd9;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.valid_i = bus.stall_o;
        end
        bus.valid_i = 1'b0;
        // accept lands in the same cycle as the MUL result
        issue(3'b010, 32'd100, 32'd23);
        issue(3'b011, 32'h0001_0000, 32'h0001_0000);
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(3'b011, 32'h1234_5678, 32'd0);

        // undefined codes
        issue(3'b111, 32'd4, 32'd4);
        issue(3'b010, 32'd1, 32'd1);
        issue(3'b100, 32'd8, 32'd2);
        issue(3'b101, 32'd8, 32'd2);
        idle();

        for (int i = 0; i < 12; i++) begin
            issue(3'($urandom_range(0, 7)), $urandom, $urandom);
        end
        idle();

        // reset 10 cycles into a MUL aborts it without a result
        issue(3'b011, 32'd3, 32'hFFFF_FFFF);
        idle();
        repeat (9) @(negedge clk);
        check("mid_mul_stall", 64'(bus.stall_o), 64'd1);
        rst = 1'b1;
        void'(sb.pop_back());
        @(negedge clk);
        check("abort_stall", 64'(bus.stall_o), 64'd0);
        check("abort_ready", 64'(bus.ready_o), 64'd1);
        check("abort_result", 64'(bus.result_o), 64'd0);
        check("abort_valid", 64'(bus.valid_o), 64'd0);
        rst = 1'b0;
        issue(3'b000, 32'hC, 32'hA);
        idle();

        for (int n = 0; n < 100 && sb.size() != 0; n++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("drain", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
